// File: rtl/instr_exec_unit_if.sv
// Instruction-in / result-out handshake bundle for instr_exec_unit.
// The master drives instruction words and out_ready. The slave (the unit) drives in_ready and the result.
interface instr_exec_unit_if #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [OP_W-1:0]   in_op_a;
  logic [OP_W-1:0]   in_op_b;
  logic [ADDR_W-1:0] in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic [ADDR_W-1:0] out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_opcode, in_op_a, in_op_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_op_a, in_op_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/instr_exec_unit.sv
// Execution stage: single-cycle ALU/multiply plus an iterative restoring divider for DIV/MOD.
// A word moves on either port at a rising edge where valid && ready. valid and payload hold until that edge.
module instr_exec_unit #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_exec_unit_if.slave  bus,
  output logic              dbg_state
);
  typedef enum logic {IDLE = 1'b0, DIVIDE = 1'b1} state_t;

  localparam int             CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OP_W - 1);

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  state_t            state, state_next;
  logic              accept, start_div, div_done;
  logic              is_div_op, b_zero;
  logic [RES_W-1:0]  a_ext, b_ext, sc_result;
  logic              sc_err;
  logic [OP_W-1:0]   mag_a, mag_b;

  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   dvd, dvs, rem;
  logic              neg_q, neg_r, is_mod;
  logic [ADDR_W-1:0] tag_q;
  logic [OP_W:0]     rem_shift, trial;
  logic [OP_W-1:0]   q_step, r_step;
  logic [RES_W-1:0]  q_ext, r_ext, div_result;

  assign a_ext     = {{(RES_W-OP_W){bus.in_op_a[OP_W-1]}}, bus.in_op_a};
  assign b_ext     = {{(RES_W-OP_W){bus.in_op_b[OP_W-1]}}, bus.in_op_b};
  assign is_div_op = (bus.in_opcode == OP_DIV) || (bus.in_opcode == OP_MOD);
  assign b_zero    = (bus.in_op_b == '0);
  assign mag_a     = bus.in_op_a[OP_W-1] ? (~bus.in_op_a) + OP_W'(1) : bus.in_op_a;
  assign mag_b     = bus.in_op_b[OP_W-1] ? (~bus.in_op_b) + OP_W'(1) : bus.in_op_b;
  assign dbg_state = state;

  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    case (bus.in_opcode)
      OP_ZERO:  sc_result = '0;
      OP_PASSA: sc_result = a_ext;
      OP_PASSB: sc_result = b_ext;
      OP_ADD:   sc_result = a_ext + b_ext;
      OP_SUB:   sc_result = a_ext - b_ext;
      OP_MULT:  sc_result = a_ext * b_ext;
      // DIV/MOD only take this path when the divisor is zero
      default:  sc_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    accept       = 1'b0;
    start_div    = 1'b0;
    div_done     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = reset_n && (!bus.out_valid || bus.out_ready);
        accept       = bus.in_ready && bus.in_valid;
        if (accept && is_div_op && !b_zero) begin
          start_div  = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt == LAST) begin
          div_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One restoring step on magnitudes: shift in the next dividend bit, subtract if it fits.
  assign rem_shift  = {rem, dvd[OP_W-1]};
  assign trial      = rem_shift - {1'b0, dvs};
  assign r_step     = trial[OP_W] ? rem_shift[OP_W-1:0] : trial[OP_W-1:0];
  assign q_step     = {dvd[OP_W-2:0], ~trial[OP_W]};
  assign q_ext      = {{(RES_W-OP_W){1'b0}}, q_step};
  assign r_ext      = {{(RES_W-OP_W){1'b0}}, r_step};
  assign div_result = is_mod ? (neg_r ? -r_ext : r_ext) : (neg_q ? -q_ext : q_ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_mod <= 1'b0;
      tag_q  <= '0;
    end else if (start_div) begin
      cnt    <= '0;
      dvd    <= mag_a;
      dvs    <= mag_b;
      rem    <= '0;
      neg_q  <= bus.in_op_a[OP_W-1] ^ bus.in_op_b[OP_W-1];
      neg_r  <= bus.in_op_a[OP_W-1];
      is_mod <= (bus.in_opcode == OP_MOD);
      tag_q  <= bus.in_tag;
    end else if (state == DIVIDE) begin
      cnt <= cnt + CNT_W'(1);
      dvd <= q_step;
      rem <= r_step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
      bus.out_err    <= 1'b0;
    end else if (accept && !start_div) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= sc_result;
      bus.out_tag    <= bus.in_tag;
      bus.out_err    <= sc_err;
    end else if (div_done) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= div_result;
      bus.out_tag    <= tag_q;
      bus.out_err    <= 1'b0;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed words, a native-arithmetic reference model with an
// expected queue checked every cycle, and literal checks on the captured results.
module tb_instr_exec_unit;
  localparam int OP_W   = 32;
  localparam int RES_W  = 64;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dbg_state;

  instr_exec_unit_if #(.OP_W(OP_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

  instr_exec_unit #(.OP_W(OP_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RES_W-1:0]  res;
    logic [ADDR_W-1:0] tag;
    logic              err;
    logic              is_div;
    logic [31:0]       acc_edge;
    logic [31:0]       ready_edge;
  } exp_t;

  typedef struct packed {
    logic [RES_W-1:0]  res;
    logic [ADDR_W-1:0] tag;
    logic              err;
    logic [31:0]       lat;
  } got_t;

  exp_t exp_q[$];
  got_t got_log[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t cmp_e;
  got_t cmp_g;
  logic cmp_ev;
  logic cmp_er;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [OP_W-1:0] a,
                                 input logic [OP_W-1:0] b, input logic [ADDR_W-1:0] tag);
    exp_t   e;
    longint sa, sb, r;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    case (op)
      3'd0: r = 0;
      3'd1: r = sa;
      3'd2: r = sb;
      3'd3: r = sa + sb;
      3'd4: r = sa - sb;
      3'd5: r = sa * sb;
      3'd6: if (sb == 0) e.err = 1'b1; else r = sa / sb;
      default: if (sb == 0) e.err = 1'b1; else r = sa % sb;
    endcase
    e.res    = r;
    e.tag    = tag;
    e.is_div = (op >= 3'd6) && (sb != 0);
    return e;
  endfunction

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      exp_q.delete();
    end else begin
      cmp_ev = (exp_q.size() > 0) && (edge_cnt >= int'(exp_q[0].ready_edge));
      chk("out_valid", bus.out_valid, cmp_ev);
      if (cmp_ev) begin
        chk("out_result", bus.out_result, exp_q[0].res);
        chk("out_tag", bus.out_tag, exp_q[0].tag);
        chk("out_err", bus.out_err, exp_q[0].err);
      end
      cmp_er = (exp_q.size() == 0) || (cmp_ev && bus.out_ready);
      chk("in_ready", bus.in_ready, cmp_er);
      chk("dbg_state", dbg_state, (exp_q.size() > 0) && !cmp_ev && exp_q[0].is_div);
      if (bus.out_valid && bus.out_ready && cmp_ev) begin
        cmp_g.res = bus.out_result;
        cmp_g.tag = bus.out_tag;
        cmp_g.err = bus.out_err;
        cmp_g.lat = edge_cnt - int'(exp_q[0].acc_edge);
        got_log.push_back(cmp_g);
        void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        cmp_e = model(bus.in_opcode, bus.in_op_a, bus.in_op_b, bus.in_tag);
        cmp_e.acc_edge   = edge_cnt;
        cmp_e.ready_edge = edge_cnt + 1 + (cmp_e.is_div ? OP_W : 0);
        exp_q.push_back(cmp_e);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the word was taken.
  task automatic send(input logic [2:0] op, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      input logic [ADDR_W-1:0] tag, output int waits);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_op_a   = a;
    bus.in_op_b   = b;
    bus.in_tag    = tag;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for op %0d", op);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_last(input string name, input int back, input logic [63:0] res,
                          input logic [ADDR_W-1:0] tag, input logic err);
    got_t g;
    if (got_log.size() <= back) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d results captured", name, got_log.size());
    end else begin
      g = got_log[got_log.size() - 1 - back];
      chk({name, "_res"}, g.res, res);
      chk({name, "_tag"}, g.tag, tag);
      chk({name, "_err"}, g.err, err);
    end
  endtask

  function automatic int last_lat();
    if (got_log.size() == 0) return -1;
    return int'(got_log[got_log.size() - 1].lat);
  endfunction

  logic [2:0]      tab_op [6] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
  logic [OP_W-1:0] tab_a  [6] = '{32'd17, 32'd17, -32'sd17, -32'sd17, 32'd0, 32'd123456789};
  logic [OP_W-1:0] tab_b  [6] = '{-32'sd5, -32'sd5, -32'sd5, -32'sd5, 32'd3, 32'd1000};

  initial begin
    int w;
    int n_log;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_opcode = 3'd1;
    bus.in_op_a   = 32'd42;
    bus.in_op_b   = 32'd0;
    bus.in_tag    = 5'd1;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("first_idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_idle();
    chk_last("reset_held_passa", 0, 64'd42, 5'd1, 1'b0);

    send(3'd3, -32'sd7, 32'd12, 5'd3, w);
    send(3'd5, -32'sd15, 32'd15, 5'd4, w);
    chk("b2b_accept_waits", w, 0);
    wait_idle();
    chk_last("add", 1, 64'd5, 5'd3, 1'b0);
    chk_last("mult", 0, -64'sd225, 5'd4, 1'b0);
    chk("mult_latency", last_lat(), 1);

    send(3'd6, -32'sd17, 32'd5, 5'd8, w);
    wait_idle();
    chk_last("div", 0, -64'sd3, 5'd8, 1'b0);
    chk("div_latency", last_lat(), OP_W + 1);
    send(3'd7, -32'sd17, 32'd5, 5'd9, w);
    wait_idle();
    chk_last("mod", 0, -64'sd2, 5'd9, 1'b0);
    send(3'd6, 32'h8000_0000, 32'hffff_ffff, 5'd10, w);
    wait_idle();
    chk_last("div_min_neg1", 0, 64'h0000_0000_8000_0000, 5'd10, 1'b0);
    send(3'd7, 32'h8000_0000, 32'hffff_ffff, 5'd11, w);
    wait_idle();
    chk_last("mod_min_neg1", 0, 64'd0, 5'd11, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(tab_op[i], tab_a[i], tab_b[i], 5'(12 + i), w);
      wait_idle();
    end
    chk_last("mod_big", 0, 64'd789, 5'd17, 1'b0);

    send(3'd6, 32'd9, 32'd0, 5'd31, w);
    wait_idle();
    chk_last("div_by_zero", 0, 64'd0, 5'd31, 1'b1);
    chk("div_by_zero_latency", last_lat(), 1);
    send(3'd3, 32'd1, 32'd1, 5'd2, w);
    wait_idle();
    chk_last("add_after_dbz", 0, 64'd2, 5'd2, 1'b0);

    bus.out_ready = 1'b0;
    send(3'd4, 32'd3, 32'd10, 5'd5, w);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_held_result", bus.out_result, -64'sd7);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send(3'd1, 32'd77, 32'd0, 5'd6, w);
    chk("bp_same_cycle_accept", w, 0);
    wait_idle();
    chk_last("bp_sub", 1, -64'sd7, 5'd5, 1'b0);
    chk_last("bp_next", 0, 64'd77, 5'd6, 1'b0);

    send(3'd6, 32'd100, 32'd7, 5'd9, w);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_div_rst_out_valid", bus.out_valid, 0);
    chk("mid_div_rst_state", dbg_state, 0);
    n_log = got_log.size();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_stale_result", got_log.size(), n_log);
    send(3'd2, 32'd0, 32'd4, 5'd7, w);
    wait_idle();
    chk_last("passb_after_rst", 0, 64'd4, 5'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
